// File: rtl/bcd_pkg.sv
// Shared constants for the BCD tick counter: digit width, largest legal
// digit, active-low seven-segment glyphs (segment order g..a) and small
// helpers for validating and converting BCD digit pairs.
package bcd_pkg;

  // A BCD digit is one nibble; codes above 9 are not legal digits.
  localparam int             BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Active-low glyphs, bit 6 = segment g ... bit 0 = segment a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // True when the nibble is a legal decimal digit.
  function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

  // Binary value of a tens:ones pair. Wide enough for illegal nibbles too
  // (15*10+15 = 165), so range checks on raw load data cannot overflow.
  function automatic logic [7:0] bcd_to_bin(input logic [BCD_W-1:0] t,
                                            input logic [BCD_W-1:0] o);
    return (8'(t) * 8'd10) + 8'(o);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Purpose: decode one BCD digit to an active-low seven-segment pattern (g..a).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input, illegal codes show blank.
module bcd_to_7seg
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  // Glyph lookup; anything outside 0..9 blanks the display.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_tick_counter.sv
// Purpose: two-digit BCD up/down counter stepped by rising edges of a slow
//          divided square wave, treated as data in the clk domain.
// Latency: tick_in first sampled high at edge k -> digits update at edge k+2;
//          seven-segment outputs (BCD_TICK_SEG_EN) lag the digits by one clk.
// Backpressure: none; steps arriving while en=0 are dropped, never queued.
//
// Optional feature macro: BCD_TICK_SEG_EN adds registered hex_tens/hex_ones.
module bcd_tick_counter
  import bcd_pkg::*;
#(
  parameter int MAX_VALUE = 59   // terminal count, legal 1..99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             carry
`ifdef BCD_TICK_SEG_EN
  ,
  output logic [6:0]       hex_tens,
  output logic [6:0]       hex_ones
`endif
);

  // Terminal count split into digits so wrap detection is a digit compare.
  localparam logic [BCD_W-1:0] MAX_TENS = 4'(MAX_VALUE / 10);
  localparam logic [BCD_W-1:0] MAX_ONES = 4'(MAX_VALUE % 10);
  localparam logic [7:0]       MAX_BIN  = 8'(MAX_VALUE);

  logic             s1, s2, s3;
  logic             step;
  logic             load_ok;
  logic             at_max;
  logic             at_zero;
  logic [BCD_W-1:0] tens_nxt;
  logic [BCD_W-1:0] ones_nxt;
  logic             carry_nxt;

  // Synchroniser plus edge-history flop. Resetting all three high means a
  // tick_in already high at reset release looks like "no edge", and any
  // edge in flight when reset hits is thrown away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // One-clk step per rising edge of the synchronised tick.
  assign step = s2 & ~s3;

  // Load data is only taken when it is a real BCD value inside the range.
  assign load_ok = bcd_digit_ok(load_tens) && bcd_digit_ok(load_ones) &&
                   (bcd_to_bin(load_tens, load_ones) <= MAX_BIN);

  assign at_max  = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign at_zero = (tens == '0) && (ones == '0);

  // Next count: clr beats load beats an enabled step; carry only on wrap.
  always_comb begin
    tens_nxt  = tens;
    ones_nxt  = ones;
    carry_nxt = 1'b0;
    if (clr) begin
      tens_nxt = '0;
      ones_nxt = '0;
    end else if (load) begin
      if (load_ok) begin
        tens_nxt = load_tens;
        ones_nxt = load_ones;
      end else begin
        tens_nxt = '0;
        ones_nxt = '0;
      end
    end else if (step && en) begin
      if (up) begin
        if (at_max) begin
          tens_nxt  = '0;
          ones_nxt  = '0;
          carry_nxt = 1'b1;
        end else if (ones == BCD_MAX) begin
          ones_nxt = '0;
          tens_nxt = tens + 4'd1;
        end else begin
          ones_nxt = ones + 4'd1;
        end
      end else begin
        if (at_zero) begin
          tens_nxt  = MAX_TENS;
          ones_nxt  = MAX_ONES;
          carry_nxt = 1'b1;
        end else if (ones == '0) begin
          ones_nxt = BCD_MAX;
          tens_nxt = tens - 4'd1;
        end else begin
          ones_nxt = ones - 4'd1;
        end
      end
    end
  end

  // Count and carry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens  <= '0;
      ones  <= '0;
      carry <= 1'b0;
    end else begin
      tens  <= tens_nxt;
      ones  <= ones_nxt;
      carry <= carry_nxt;
    end
  end

`ifdef BCD_TICK_SEG_EN
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;

  bcd_to_7seg u_seg_tens (
    .bcd (tens),
    .seg (seg_tens)
  );

  bcd_to_7seg u_seg_ones (
    .bcd (ones),
    .seg (seg_ones)
  );

  // Register the decoded glyphs so the display pins are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hex_tens <= SEG_0;
      hex_ones <= SEG_0;
    end else begin
      hex_tens <= seg_tens;
      hex_ones <= seg_ones;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Testbench for bcd_tick_counter: table of single-step vectors plus
// hand-written sequences for reset, full count cycle, enable gating and
// asynchronous reset mid-count.
module tb_bcd_tick_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       carry;
`ifdef BCD_TICK_SEG_EN
  logic [6:0] hex_tens;
  logic [6:0] hex_ones;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_carry = 0;

  bcd_tick_counter #(.MAX_VALUE(59)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .en        (en),
    .up        (up),
    .clr       (clr),
    .load      (load),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .tens      (tens),
    .ones      (ones),
    .carry     (carry)
`ifdef BCD_TICK_SEG_EN
    ,
    .hex_tens  (hex_tens),
    .hex_ones  (hex_ones)
`endif
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] lt;
    logic [3:0] lo;
    logic [3:0] et;
    logic [3:0] eo;
    logic       ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic tick, input logic e, input logic u,
                     input logic c, input logic l,
                     input logic [3:0] lt, input logic [3:0] lo,
                     input logic [3:0] et, input logic [3:0] eo,
                     input logic ec);
    vec_t v;
    v.tick = tick; v.en = e; v.up = u; v.clr = c; v.load = l;
    v.lt = lt; v.lo = lo; v.et = et; v.eo = eo; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic chk_cnt(input string name, input logic [3:0] et,
                         input logic [3:0] eo, input logic ec);
    n_cmp++;
    if (tens !== et || ones !== eo || carry !== ec) begin
      n_bad++;
      $display("FAIL %s: got %0d%0d carry=%0b, expected %0d%0d carry=%0b",
               name, tens, ones, carry, et, eo, ec);
    end
  endtask

  task automatic chk7(input string name, input logic [6:0] act,
                      input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One tick_in rising edge with latency checks: unchanged after edges k and
  // k+1, updated after k+2, carry gone one cycle later.
  task automatic tick_step(input string name,
                           input logic [3:0] pt, input logic [3:0] po,
                           input logic [3:0] et, input logic [3:0] eo,
                           input logic ec);
    @(negedge clk);
    tick_in = 1'b1;
    @(negedge clk);
    chk_cnt({name, "_k"}, pt, po, 1'b0);
    @(negedge clk);
    chk_cnt({name, "_k1"}, pt, po, 1'b0);
    @(negedge clk);
    chk_cnt({name, "_k2"}, et, eo, ec);
    if (carry === 1'b1) n_carry++;
    tick_in = 1'b0;
    @(negedge clk);
    chk_cnt({name, "_after"}, et, eo, 1'b0);
  endtask

  // Apply one table vector; for tick vectors clr/load are raised in the
  // same cycle that the step reaches the counter.
  task automatic apply_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    en = v.en;
    up = v.up;
    if (v.tick) begin
      tick_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
    end
    clr       = v.clr;
    load      = v.load;
    load_tens = v.lt;
    load_ones = v.lo;
    @(negedge clk);
    chk_cnt(nm, v.et, v.eo, v.ec);
    clr     = 1'b0;
    load    = 1'b0;
    tick_in = 1'b0;
    en      = 1'b0;
    @(negedge clk);
    chk_cnt({nm, "_hold"}, v.et, v.eo, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    // tick, en, up, clr, load, lt, lo, exp tens, exp ones, exp carry
    add(0, 0, 1, 0, 1, 4'd4, 4'd5,  4'd4, 4'd5, 0);  // legal load
    add(0, 0, 1, 0, 1, 4'd7, 4'd0,  4'd0, 4'd0, 0);  // 70 > max
    add(0, 0, 1, 0, 1, 4'd4, 4'd5,  4'd4, 4'd5, 0);
    add(0, 0, 1, 0, 1, 4'd4, 4'hA,  4'd0, 4'd0, 0);  // illegal digit
    add(0, 0, 1, 0, 1, 4'd5, 4'd9,  4'd5, 4'd9, 0);  // exactly max
    add(0, 0, 1, 0, 1, 4'd6, 4'd0,  4'd0, 4'd0, 0);  // max+1
    add(0, 0, 1, 0, 1, 4'd2, 4'd0,  4'd2, 4'd0, 0);
    add(1, 1, 0, 0, 0, 4'd0, 4'd0,  4'd1, 4'd9, 0);  // 20 -> 19
    add(0, 0, 1, 0, 1, 4'd1, 4'd0,  4'd1, 4'd0, 0);
    add(1, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd9, 0);  // 10 -> 09
    add(1, 1, 0, 0, 0, 4'd0, 4'd0,  4'd0, 4'd8, 0);
    add(0, 0, 1, 0, 1, 4'd0, 4'd0,  4'd0, 4'd0, 0);
    add(1, 1, 0, 0, 0, 4'd0, 4'd0,  4'd5, 4'd9, 1);  // 00 -> 59 wrap
    add(1, 1, 1, 0, 0, 4'd0, 4'd0,  4'd0, 4'd0, 1);  // 59 -> 00 wrap
    add(0, 0, 1, 0, 1, 4'd1, 4'd2,  4'd1, 4'd2, 0);
    add(1, 1, 1, 1, 1, 4'd3, 4'd3,  4'd0, 4'd0, 0);  // clr wins
    add(0, 0, 1, 0, 1, 4'd1, 4'd2,  4'd1, 4'd2, 0);
    add(1, 1, 1, 0, 1, 4'd3, 4'd3,  4'd3, 4'd3, 0);  // load wins over step
    add(1, 1, 1, 0, 0, 4'd0, 4'd0,  4'd3, 4'd4, 0);
    add(1, 0, 1, 0, 0, 4'd0, 4'd0,  4'd3, 4'd4, 0);  // en=0 drops step
    add(0, 0, 1, 0, 1, 4'd0, 4'd9,  4'd0, 4'd9, 0);
    add(1, 1, 1, 0, 0, 4'd0, 4'd0,  4'd1, 4'd0, 0);  // 09 -> 10
    add(0, 0, 1, 0, 1, 4'd2, 4'd2,  4'd2, 4'd2, 0);
    add(0, 0, 1, 1, 0, 4'd0, 4'd0,  4'd0, 4'd0, 0);  // clr alone
    add(0, 0, 1, 0, 1, 4'd9, 4'd9,  4'd0, 4'd0, 0);  // 99 > max

    // Reset state, with tick_in already high.
    #5;
    chk_cnt("reset", 4'd0, 4'd0, 1'b0);
`ifdef BCD_TICK_SEG_EN
    chk7("reset_hex_tens", hex_tens, 7'b1000000);
    chk7("reset_hex_ones", hex_ones, 7'b1000000);
`endif
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    up  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk_cnt($sformatf("hold_high%0d", i), 4'd0, 4'd0, 1'b0);
    end

    // Full up-count cycle 00..59,00.
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    up = 1'b1;
    n_carry = 0;
    for (int i = 0; i < 60; i++) begin
      int nv;
      nv = (i == 59) ? 0 : i + 1;
      tick_step($sformatf("up%0d", i), 4'(i / 10), 4'(i % 10),
                4'(nv / 10), 4'(nv % 10), (i == 59));
    end
    n_cmp++;
    if (n_carry != 1) begin
      n_bad++;
      $display("FAIL carry_count: got %0d pulses, expected 1", n_carry);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Table vectors.
    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Enable gating: five edges with en=0, then en rises with nothing owed.
    @(negedge clk);
    load = 1'b1; load_tens = 4'd2; load_ones = 4'd5;
    @(negedge clk);
    load = 1'b0;
    chk_cnt("load25", 4'd2, 4'd5, 1'b0);
    en = 1'b0;
    up = 1'b1;
    for (int i = 0; i < 5; i++)
      tick_step($sformatf("en_off%0d", i), 4'd2, 4'd5, 4'd2, 4'd5, 1'b0);
    en = 1'b1;
    repeat (6) @(negedge clk);
    chk_cnt("en_rise", 4'd2, 4'd5, 1'b0);
    tick_step("en_on", 4'd2, 4'd5, 4'd2, 4'd6, 1'b0);

    // Load 37 and check the display lag.
    @(negedge clk);
    load = 1'b1; load_tens = 4'd3; load_ones = 4'd7;
    @(negedge clk);
    load = 1'b0;
    chk_cnt("load37", 4'd3, 4'd7, 1'b0);
`ifdef BCD_TICK_SEG_EN
    chk7("hex_tens_lag", hex_tens, 7'b0100100);
    chk7("hex_ones_lag", hex_ones, 7'b0000010);
    @(negedge clk);
    chk7("hex_tens_37", hex_tens, 7'b0110000);
    chk7("hex_ones_37", hex_ones, 7'b1111000);
`endif

    // Asynchronous reset mid-count with an edge already in the synchroniser.
    @(negedge clk);
    tick_in = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_cnt("async_rst", 4'd0, 4'd0, 1'b0);
`ifdef BCD_TICK_SEG_EN
    chk7("async_rst_hex_tens", hex_tens, 7'b1000000);
    chk7("async_rst_hex_ones", hex_ones, 7'b1000000);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_cnt("rst_release_high", 4'd0, 4'd0, 1'b0);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    up = 1'b1;
    tick_step("first_edge", 4'd0, 4'd0, 4'd0, 4'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
- Two-digit BCD counter that consumes the slow square wave produced by the board clock divider (1 Hz at 50 MHz clk).
- Runs entirely in the 50 MHz clk domain. The divided signal is treated as data: it is synchronised, rising-edge detected, and each edge advances the count by one.
- Outputs feed the seven-segment display stage and any cascaded next counter (via carry).

Parameters:
- MAX_VALUE, 59, terminal count in decimal. Legal range 1..99. The count runs 00..MAX_VALUE.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-low
- tick_in  in  1  divided square wave; one count step per rising edge
- en  in  1  count enable; steps arriving while en=0 are discarded, not queued
- up  in  1  direction: 1 = increment, 0 = decrement
- clr  in  1  synchronous clear to 00
- load  in  1  synchronous load of load_tens:load_ones
- load_tens  in  4  BCD tens digit for load
- load_ones  in  4  BCD ones digit for load
- tens  out  4  BCD tens digit, registered
- ones  out  4  BCD ones digit, registered
- carry  out  1  one-clk pulse on wrap, in either direction

Behaviour:
- Reset (rst=0, asynchronous):
  - tens=0, ones=0, carry=0.
  - Synchroniser flops s1, s2, s3 all reset to 1. A tick_in that is already high at reset release therefore produces no step; the first genuine rising edge after release does.
- Synchroniser and edge detect:
  - s1<=tick_in, s2<=s1, s3<=s2 on each clk edge.
  - step = s2 & ~s3 (combinational), one clk wide per tick_in rising edge.
- Latency: if tick_in is first sampled high at clk edge k, the count updates at edge k+2.
  - Falling edges of tick_in have no effect.
- Priority per clk edge: clr > load > (step & en). All lower-priority actions are ignored that cycle.
- clr: tens=0, ones=0, carry=0.
- load:
  - Accepted only if both digits are <=9 and tens*10+ones <= MAX_VALUE; otherwise loads 00.
  - carry=0.
- Increment (step & en & up):
  - ones<9: ones+1.
  - ones=9: ones=0, tens+1.
  - At count==MAX_VALUE: next value is 00, and carry=1 for one cycle.
- Decrement (step & en & ~up):
  - ones>0: ones-1.
  - ones=0: ones=9, tens-1.
  - At 00: next value is MAX_VALUE, and carry=1 for one cycle.
- carry is 0 in every cycle without a wrap. It never stays high for 2 consecutive cycles, because steps are at least 2 clk apart.
- Digits never leave the range 0..9, and the value never exceeds MAX_VALUE.
- Direction change takes effect on the next step; no pipeline to flush.
- Reset mid-count: immediate return to reset values; any pending edge in s1/s2 is discarded.

Optional Feature:
- Macro: BCD_TICK_SEG_EN.
- Defined:
  - Adds outputs hex_tens[6:0] and hex_ones[6:0]: active-low seven-segment patterns (segment order g..a) for tens and ones.
  - Registered, so they lag the digits by 1 clk. Reset value 7'b1000000 (glyph "0").
- Undefined: those ports and their logic do not exist; interface is as listed above.

Decomposition:
- Package bcd_pkg:
  - BCD digit width constant (4) and the max BCD digit (9).
  - The seven-segment active-low glyph constants for 0-9, plus blank (7'b1111111) for illegal codes.
- Sub-module bcd_to_7seg: combinational 4-bit BCD to 7-bit active-low segment decode. Instantiated twice, only under BCD_TICK_SEG_EN.

Test Plan:
- Reset release with tick_in=1, then hold tick_in high for 100 clk -> count stays 00, carry stays 0.
- en=1, up=1, 60 tick_in rising edges -> sequence 00,01..09,10..59,00. Exactly one carry pulse (1 clk), coincident with the 59->00 update. Each update occurs 2 clk after tick_in is first sampled high.
- up=0 from 00, one edge -> 59 with carry pulse. Load 20, one edge -> 19. Load 10, one edge -> 09.
- load_tens=7, load_ones=0 (70 > MAX_VALUE) -> 00; load 4:A (illegal digit) -> 00; load 4:5 -> 45.
- clr, load and step all asserted in the same cycle -> 00. load and step in the same cycle -> loaded value, no increment. en=0 across 5 edges -> count unchanged, and no step is applied after en rises.
- rst asserted asynchronously mid-count at 37 -> outputs 00 immediately. With BCD_TICK_SEG_EN defined, count 37 -> hex_tens=7'b0110000, hex_ones=7'b1111000, one clk after the digits update.
